// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multicycle control FSM (slave side) and the datapath (master side).
// mem_ready acts as the ready half of a request/ready handshake: dmem_re or we_data_mem is the request.
interface mc_ctrl_fsm_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [3:0]       ALU_Sel;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             we_fr;
    logic             dmem_re;
    logic             we_data_mem;
    logic             illegal_op;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_cnt;

    modport slave (
        input  op, funct, zero, mem_ready,
        output ir_we, pc_we, pc_src, alu_src_a, alu_src_b, ALU_Sel, reg_dst,
               mem_to_reg, we_fr, dmem_re, we_data_mem, illegal_op, state, instr_cnt
    );

    modport master (
        output op, funct, zero, mem_ready,
        input  ir_we, pc_we, pc_src, alu_src_a, alu_src_b, ALU_Sel, reg_dst,
               mem_to_reg, we_fr, dmem_re, we_data_mem, illegal_op, state, instr_cnt
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Moore control FSM for the multicycle MIPS datapath (LW, SW, R-type, BEQ, ADDI, J).
// Define CTRL_PERF_CNT_EN to build the retired-instruction counter; otherwise instr_cnt is 0.
module mc_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input logic          clk,
    input logic          rst,
    mc_ctrl_fsm_if.slave bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
    } state_t;

    typedef struct packed {
        logic       ir_we;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_sel;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       we_fr;
        logic       dmem_re;
        logic       we_data_mem;
    } ctrl_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110, ALU_SLT = 4'b0111;

    function automatic logic funct_ok(input logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    function automatic logic [3:0] funct_sel(input logic [5:0] f);
        case (f)
            6'b100010: return ALU_SUB;
            6'b100100: return ALU_AND;
            6'b100101: return ALU_OR;
            6'b101010: return ALU_SLT;
            default:   return ALU_ADD;
        endcase
    endfunction

    // Outputs for the state being entered, so the register holds them for that whole state.
    function automatic ctrl_t decode(input state_t s, input logic [5:0] f);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:  begin c.ir_we = 1'b1; c.pc_write = 1'b1; c.alu_src_b = 2'b01; c.alu_sel = ALU_ADD; end
            S_DECODE: begin c.alu_src_b = 2'b11; c.alu_sel = ALU_ADD; end
            S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_sel = ALU_ADD; end
            S_MEMRD:  c.dmem_re = 1'b1;
            S_MEMWB:  begin c.we_fr = 1'b1; c.mem_to_reg = 1'b1; end
            S_MEMWR:  c.we_data_mem = 1'b1;
            S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_sel = funct_sel(f); end
            S_ALUWB:  begin c.we_fr = 1'b1; c.reg_dst = 1'b1; end
            S_BRANCH: begin c.alu_src_a = 1'b1; c.alu_sel = ALU_SUB; c.branch = 1'b1; c.pc_src = 2'b01; end
            S_ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_sel = ALU_ADD; end
            S_ADDIWB: c.we_fr = 1'b1;
            S_JUMP:   begin c.pc_write = 1'b1; c.pc_src = 2'b10; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    state_t state;
    state_t nxt;
    ctrl_t  ctrl;
    ctrl_t  ctrl_o;
    logic   legal;

    assign legal = (bus.op == OP_R) ? funct_ok(bus.funct)
                 : (bus.op inside {OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});

    always_comb begin
        nxt = S_FETCH;
        case (state)
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: begin
                if (legal) begin
                    case (bus.op)
                        OP_LW, OP_SW: nxt = S_MEMADR;
                        OP_R:         nxt = S_EXEC;
                        OP_BEQ:       nxt = S_BRANCH;
                        OP_ADDI:      nxt = S_ADDIEX;
                        OP_J:         nxt = S_JUMP;
                        default:      nxt = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: nxt = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  nxt = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  nxt = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   nxt = S_ALUWB;
            S_ADDIEX: nxt = S_ADDIWB;
            default:  nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            ctrl  <= decode(S_FETCH, bus.funct);
        end else begin
            state <= nxt;
            ctrl  <= decode(nxt, bus.funct);
        end
    end

    // Reset overrides every output, including the registered ones already primed for FETCH.
    assign ctrl_o          = rst ? '0 : ctrl;
    assign bus.ir_we       = ctrl_o.ir_we;
    assign bus.pc_we       = ctrl_o.pc_write | (ctrl_o.branch & bus.zero);
    assign bus.pc_src      = ctrl_o.pc_src;
    assign bus.alu_src_a   = ctrl_o.alu_src_a;
    assign bus.alu_src_b   = ctrl_o.alu_src_b;
    assign bus.ALU_Sel     = ctrl_o.alu_sel;
    assign bus.reg_dst     = ctrl_o.reg_dst;
    assign bus.mem_to_reg  = ctrl_o.mem_to_reg;
    assign bus.we_fr       = ctrl_o.we_fr;
    assign bus.dmem_re     = ctrl_o.dmem_re;
    assign bus.we_data_mem = ctrl_o.we_data_mem;
    assign bus.illegal_op  = ~rst & (state == S_DECODE) & ~legal;
    assign bus.state       = rst ? 4'd0 : state;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cnt;
    logic             retire;

    assign retire = (state inside {S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP})
                  | ((state == S_MEMWR) & bus.mem_ready);

    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (retire) cnt <= cnt + 1'b1;
    end

    assign bus.instr_cnt = rst ? {CNT_W{1'b0}} : cnt;
`else
    assign bus.instr_cnt = {CNT_W{1'b0}};
`endif
endmodule
